// File: rtl/prime_lane_scheduler_if.sv
// Scheduler-side bundle: job control/status toward the top-level glue and the
// launch/result vectors toward the prime-checker lane array.
interface prime_lane_scheduler_if #(
    parameter int unsigned N_UNITS = 8,
    parameter int unsigned WIDTH   = 32
);
    logic                       start;
    logic [WIDTH-1:0]           test_number;
    logic                       busy;
    logic                       done;
    logic                       found;
    logic [WIDTH-1:0]           prime_val;
    logic [WIDTH-1:0]           orig_val;
    logic [WIDTH-1:0]           count;
    logic [2:0]                 state;
    logic [N_UNITS-1:0]         unit_start;
    logic [N_UNITS*WIDTH-1:0]   unit_value;
    logic [N_UNITS-1:0]         unit_done;
    logic [N_UNITS-1:0]         unit_is_prime;

    modport slave (
        input  start, test_number, unit_done, unit_is_prime,
        output busy, done, found, prime_val, orig_val, count, state,
               unit_start, unit_value
    );

    modport master (
        output start, test_number, unit_done, unit_is_prime,
        input  busy, done, found, prime_val, orig_val, count, state,
               unit_start, unit_value
    );
endinterface

// File: rtl/prime_lane_scheduler.sv
// Issues consecutive candidates to N_UNITS checker lanes and retires their verdicts
// strictly in ascending order to report the smallest prime >= test_number.
module prime_lane_scheduler #(
    parameter int unsigned N_UNITS  = 8,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_SPAN = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    prime_lane_scheduler_if.slave bus
);

    localparam int unsigned      LW   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SPAN = WIDTH'(MAX_SPAN);
    localparam logic [WIDTH-1:0] NU   = WIDTH'(N_UNITS);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_RUN   = 3'b010,
        S_DRAIN = 3'b011,
        S_DONE  = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   orig_q, orig_d, count_q, count_d, next_q, next_d, prime_q, prime_d;
    logic               found_q, found_d, exh_q, exh_d, busy_q, busy_d, done_q, done_d;
    logic [N_UNITS-1:0] pend_q, pend_d, rv_q, rv_d, rp_q, rp_d, ustart_q, ustart_d;
    logic [1:0]         dly_q [N_UNITS];
    logic [1:0]         dly_d [N_UNITS];
    logic [WIDTH-1:0]   val_q [N_UNITS];
    logic [WIDTH-1:0]   val_d [N_UNITS];

    logic               start_acc, free_hit, ret_hit, all_cap, issue_go, ret_go;
    logic               ret_prime, span_stop;
    logic [LW-1:0]      free_idx, ret_idx;
    logic [WIDTH-1:0]   tn_base, orig_base, count_inc;

    // Lane scan: lowest free lane, the lane holding the in-order candidate, drain status
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        ret_hit  = 1'b0;
        ret_idx  = '0;
        all_cap  = 1'b1;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (!pend_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = LW'(i);
            end
            if (pend_q[i] && rv_q[i] && (val_q[i] == count_q)) begin
                ret_hit = 1'b1;
                ret_idx = LW'(i);
            end
            if (pend_q[i] && !rv_q[i]) all_cap = 1'b0;
        end
        start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        tn_base   = (bus.test_number < TWO) ? TWO : bus.test_number;
        orig_base = (orig_q < TWO) ? TWO : orig_q;
        count_inc = (count_q == MAXV) ? MAXV : count_q + WIDTH'(1);
        ret_prime = rp_q[ret_idx];
        span_stop = (count_q == MAXV) || ((count_inc - orig_base) == SPAN);
        issue_go  = ((state_q == S_LOAD) || (state_q == S_RUN)) && free_hit
                    && ((next_q - count_q) < NU) && !exh_q;
        ret_go    = (state_q == S_RUN) && ret_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start_acc) state_d = S_LOAD;
            S_LOAD:         state_d = S_RUN;
            S_RUN:          if (ret_go && (ret_prime || span_stop)) state_d = S_DRAIN;
            S_DRAIN:        if (all_cap) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        orig_d   = orig_q;
        count_d  = count_q;
        next_d   = next_q;
        prime_d  = prime_q;
        found_d  = found_q;
        exh_d    = exh_q;
        pend_d   = pend_q;
        rv_d     = rv_q;
        rp_d     = rp_q;
        dly_d    = dly_q;
        val_d    = val_q;
        ustart_d = '0;

        if (start_acc) begin
            orig_d  = bus.test_number;
            count_d = tn_base;
            next_d  = tn_base;
            found_d = 1'b0;
            exh_d   = 1'b0;
        end

        // done is ignored until the lane has had a full cycle to drop its previous result
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (pend_q[i] && !rv_q[i]) begin
                if (dly_q[i] != 2'd0) begin
                    dly_d[i] = dly_q[i] - 2'd1;
                end else if (bus.unit_done[i]) begin
                    rv_d[i] = 1'b1;
                    rp_d[i] = bus.unit_is_prime[i];
                end
            end
        end

        if (issue_go) begin
            pend_d[free_idx]   = 1'b1;
            rv_d[free_idx]     = 1'b0;
            dly_d[free_idx]    = 2'd2;
            val_d[free_idx]    = next_q;
            ustart_d[free_idx] = 1'b1;
            if (next_q == MAXV) exh_d = 1'b1;
            else                next_d = next_q + WIDTH'(1);
        end

        if (ret_go) begin
            if (ret_prime) begin
                prime_d = count_q;
                found_d = 1'b1;
            end else begin
                pend_d[ret_idx] = 1'b0;
                rv_d[ret_idx]   = 1'b0;
                count_d         = count_inc;
                if (span_stop) found_d = 1'b0;
            end
        end

        if ((state_q == S_DRAIN) && all_cap) begin
            pend_d = '0;
            rv_d   = '0;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orig_q   <= '0;
            count_q  <= '0;
            next_q   <= '0;
            prime_q  <= '0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= '0;
            rv_q     <= '0;
            rp_q     <= '0;
            ustart_q <= '0;
            for (int unsigned i = 0; i < N_UNITS; i++) begin
                dly_q[i] <= 2'd0;
                val_q[i] <= '0;
            end
        end else begin
            orig_q   <= orig_d;
            count_q  <= count_d;
            next_q   <= next_d;
            prime_q  <= prime_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            rv_q     <= rv_d;
            rp_q     <= rp_d;
            ustart_q <= ustart_d;
            dly_q    <= dly_d;
            val_q    <= val_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.found      = found_q;
    assign bus.prime_val  = prime_q;
    assign bus.orig_val   = orig_q;
    assign bus.count      = count_q;
    assign bus.state      = state_q;
    assign bus.unit_start = ustart_q;

    for (genvar g = 0; g < N_UNITS; g++) begin : g_val
        assign bus.unit_value[g*WIDTH +: WIDTH] = val_q[g];
    end

endmodule

// File: tb/tb_prime_lane_scheduler.sv
// Scoreboard bench for prime_lane_scheduler: lane models with random latency,
// a candidate-walking reference model, and a done-edge monitor.
module tb_prime_lane_scheduler;
    localparam int unsigned N    = 8;
    localparam int unsigned W    = 32;
    localparam int unsigned SPAN = 16;
    localparam longint      MAXV = 64'h0000_0000_FFFF_FFFF;
    localparam int          TMO  = 4000;

    typedef struct {
        longint orig;
        bit     found;
        longint prime;
        longint count;
        bit     chk_count;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    prime_lane_scheduler_if #(.N_UNITS(N), .WIDTH(W)) bus ();

    prime_lane_scheduler #(.N_UNITS(N), .WIDTH(W), .MAX_SPAN(SPAN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t   sb_q[$];
    int     checks = 0;
    int     failures = 0;
    longint exp_issue = 0;
    bit     lat_special = 1'b0;
    bit     done_prev = 1'b0;
    bit     ln_arm [N];
    int     ln_cnt [N];
    longint ln_val [N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input longint n);
        if (n < 2) return 1'b0;
        if (n < 4) return 1'b1;
        if (n % 2 == 0) return 1'b0;
        for (longint d = 3; d * d <= n; d += 2)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Walk candidates upward from max(n,2) until a prime, the span limit, or the top value
    function automatic exp_t model(input longint n);
        exp_t   e;
        longint base;
        longint c;
        base        = (n < 2) ? 2 : n;
        e.orig      = n;
        e.found     = 1'b0;
        e.prime     = 0;
        e.count     = base + SPAN;
        e.chk_count = 1'b1;
        for (longint k = 0; k < SPAN; k++) begin
            c = base + k;
            if (is_prime(c)) begin
                e.found = 1'b1;
                e.prime = c;
                e.count = c;
                return e;
            end
            if (c == MAXV) begin
                e.chk_count = 1'b0;
                return e;
            end
        end
        return e;
    endfunction

    function automatic int lane_lat(input longint v);
        if (lat_special && v == 1013) return 2;
        if (lat_special && v == 1009) return 60;
        return int'($urandom_range(1, 40));
    endfunction

    // Checker lanes: done stays high (stale) until one cycle after a launch, then the verdict arrives
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                bus.unit_done[i]     = 1'b1;
                bus.unit_is_prime[i] = 1'b1;
                ln_arm[i] = 1'b0;
                ln_cnt[i] = 0;
                ln_val[i] = 0;
            end else begin
                if (ln_cnt[i] != 0) begin
                    ln_cnt[i]--;
                    if (ln_cnt[i] == 0) begin
                        bus.unit_done[i]     = 1'b1;
                        bus.unit_is_prime[i] = is_prime(ln_val[i]);
                    end
                end
                if (ln_arm[i]) begin
                    ln_arm[i]        = 1'b0;
                    bus.unit_done[i] = 1'b0;
                    ln_cnt[i]        = lane_lat(ln_val[i]);
                end
                if (bus.unit_start[i]) begin
                    ln_arm[i] = 1'b1;
                    ln_val[i] = longint'(bus.unit_value[i*W +: W]);
                end
            end
        end
    end

    // Monitor: issue order/window and result retirement against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        longint v;
        if (!rst) begin
            if (bus.unit_start != '0) begin
                chk("issue_onehot", longint'($countones(bus.unit_start)), 1);
                for (int i = 0; i < N; i++) begin
                    if (bus.unit_start[i]) begin
                        v = longint'(bus.unit_value[i*W +: W]);
                        chk("issue_value", v, exp_issue);
                        chk("issue_window", longint'((v - longint'(bus.count)) < N), 1);
                        exp_issue++;
                    end
                end
            end
            if (bus.done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: orig_val=%0d with no job outstanding", bus.orig_val);
                end else begin
                    e = sb_q.pop_front();
                    chk("orig_val", longint'(bus.orig_val), e.orig);
                    chk("found", longint'(bus.found), longint'(e.found));
                    if (e.found) chk("prime_val", longint'(bus.prime_val), e.prime);
                    if (e.chk_count) chk("count", longint'(bus.count), e.count);
                    chk("done_not_busy", longint'(bus.busy), 0);
                end
            end
        end
        done_prev = bus.done;
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic run_job(input longint n, input bit poke);
        int cyc;
        sb_q.push_back(model(n));
        @(negedge clk);
        exp_issue       = (n < 2) ? 2 : n;
        bus.start       = 1'b1;
        bus.test_number = W'(n);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.test_number = $urandom;
        chk("load_state", longint'(bus.state), 1);
        chk("load_no_issue", longint'(bus.unit_start), 0);
        @(negedge clk);
        chk("first_issue", longint'(bus.unit_start != '0), 1);
        cyc = 0;
        while (!bus.done && cyc < TMO) begin
            bus.start = poke && (cyc == 3) && bus.busy;
            if (bus.start) bus.test_number = $urandom;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: n=%0d no done within %0d cycles", n, TMO);
            reset_dut();
        end
    endtask

    initial begin
        longint n;
        int     sel;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.test_number = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", longint'(bus.state), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_found", longint'(bus.found), 0);
        chk("rst_prime_val", longint'(bus.prime_val), 0);
        chk("rst_orig_val", longint'(bus.orig_val), 0);
        chk("rst_count", longint'(bus.count), 0);
        chk("rst_unit_start", longint'(bus.unit_start), 0);
        chk("rst_unit_value", longint'(bus.unit_value != '0), 0);

        run_job(1000, 1'b0);
        run_job(1164, 1'b1);
        run_job(0, 1'b0);
        run_job(1, 1'b0);
        run_job(7, 1'b0);
        lat_special = 1'b1;
        run_job(1000, 1'b0);
        lat_special = 1'b0;
        run_job(24, 1'b1);
        run_job(524, 1'b0);
        run_job(MAXV - 5, 1'b0);
        run_job(MAXV - 3, 1'b0);
        run_job(MAXV, 1'b0);

        // Abort mid-search, then confirm a clean restart
        @(negedge clk);
        exp_issue       = 1164;
        bus.start       = 1'b1;
        bus.test_number = W'(1164);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_state", longint'(bus.state), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", longint'(bus.state), 0);
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_unit_start", longint'(bus.unit_start), 0);
        chk("abort_done", longint'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_job(1000, 1'b0);

        for (int j = 0; j < 30; j++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 13)      n = longint'($urandom_range(0, 5000));
            else if (sel < 16) n = longint'($urandom_range(500, 560));
            else               n = MAXV - longint'($urandom_range(0, 60));
            run_job(n, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", longint'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
